// File: rtl/connect4_turn_controller_if.sv
// Button/board bus between the Connect-4 turn controller and its host.
// The controller is the slave: it samples the button pulses and drives the board view.
interface connect4_turn_controller_if;
    logic        start;
    logic        btn_left;
    logic        btn_right;
    logic        btn_drop;
    logic [1:0]  state_out;
    logic [4:0]  column_position;
    logic [1:0]  cursor;
    logic        current_player;
    logic [15:0] board_occupied;
    logic [15:0] board_owner;
    logic [1:0]  winner;
    logic        game_over;

    modport master (
        output start, btn_left, btn_right, btn_drop,
        input  state_out, column_position, cursor, current_player,
        input  board_occupied, board_owner, winner, game_over
    );

    modport slave (
        input  start, btn_left, btn_right, btn_drop,
        output state_out, column_position, cursor, current_player,
        output board_occupied, board_owner, winner, game_over
    );
endinterface

// File: rtl/connect4_turn_controller.sv
// Turn sequencing for a 4x4 Connect-4 board: cursor, drop landing, shadow board,
// win/draw detection. Cell index = row*4 + col, row 0 at the bottom.
module connect4_turn_controller (
    input  logic                         clk,
    input  logic                         reset,
    connect4_turn_controller_if.slave    bus
);
    localparam int unsigned N_COLS  = 4;
    localparam int unsigned N_ROWS  = 4;
    localparam int unsigned N_CELLS = N_COLS * N_ROWS;
    localparam int unsigned N_LINES = 10;
    localparam logic [4:0]  IDLE_IDX = 5'b11111;

    // Four rows, four columns, then the two diagonals.
    localparam logic [N_LINES-1:0][N_CELLS-1:0] LINES = {
        16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
        16'h1111, 16'h2222, 16'h4444, 16'h8888,
        16'h8421, 16'h1248
    };

    typedef enum logic [2:0] {S_INIT, S_TURN, S_PLACE, S_CHECK, S_END} state_e;

    state_e               state_q, state_d;
    logic [1:0]           cursor_q, cursor_d;
    logic                 player_q, player_d;
    logic [N_CELLS-1:0]   occ_q, occ_d;
    logic [N_CELLS-1:0]   own_q, own_d;
    logic [1:0]           winner_q, winner_d;
    logic [1:0]           state_out_q, state_out_d;
    logic [4:0]           colpos_q, colpos_d;
    logic                 game_over_q, game_over_d;

    logic [4:0]           land_idx_c;
    logic                 col_full_c;
    logic [N_CELLS-1:0]   mine_c;
    logic                 win_c;

    // Lowest empty row in the cursor column; scanning downward lets the lowest one win.
    always_comb begin
        land_idx_c = IDLE_IDX;
        for (int r = int'(N_ROWS) - 1; r >= 0; r--) begin
            if (!occ_q[{2'(r), cursor_q}]) begin
                land_idx_c = {1'b0, 2'(r), cursor_q};
            end
        end
        col_full_c = occ_q[{2'(N_ROWS - 1), cursor_q}];
    end

    // A line wins only if every cell in it belongs to the player who just moved.
    always_comb begin
        mine_c = occ_q & (player_q ? own_q : ~own_q);
        win_c  = 1'b0;
        for (int i = 0; i < int'(N_LINES); i++) begin
            if ((mine_c & LINES[i]) == LINES[i]) begin
                win_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            cursor_q    <= 2'd0;
            player_q    <= 1'b0;
            occ_q       <= '0;
            own_q       <= '0;
            winner_q    <= 2'b00;
            state_out_q <= 2'b00;
            colpos_q    <= IDLE_IDX;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            player_q    <= player_d;
            occ_q       <= occ_d;
            own_q       <= own_d;
            winner_q    <= winner_d;
            state_out_q <= state_out_d;
            colpos_q    <= colpos_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        player_d = player_q;
        occ_d    = occ_q;
        own_d    = own_q;
        winner_d = winner_q;
        case (state_q)
            S_INIT: begin
                if (bus.start) begin
                    state_d  = S_TURN;
                    player_d = 1'b0;
                end
            end
            S_TURN: begin
                if (bus.btn_drop) begin
                    if (!col_full_c) begin
                        state_d = S_PLACE;
                    end
                end else if (bus.btn_left ^ bus.btn_right) begin
                    cursor_d = bus.btn_left ? cursor_q - 2'd1 : cursor_q + 2'd1;
                end
            end
            S_PLACE: begin
                occ_d[colpos_q[3:0]] = 1'b1;
                own_d[colpos_q[3:0]] = player_q;
                state_d              = S_CHECK;
            end
            S_CHECK: begin
                if (win_c) begin
                    state_d  = S_END;
                    winner_d = player_q ? 2'b10 : 2'b01;
                end else if (&occ_q) begin
                    state_d  = S_END;
                    winner_d = 2'b11;
                end else begin
                    state_d  = S_TURN;
                    player_d = ~player_q;
                end
            end
            S_END: begin
                if (bus.start) begin
                    state_d = S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
        // Entering or sitting in S_INIT always presents a clean board.
        if (state_d == S_INIT) begin
            cursor_d = 2'd0;
            player_d = 1'b0;
            occ_d    = '0;
            own_d    = '0;
            winner_d = 2'b00;
        end
    end

    // Registered outputs follow the state being entered, so they line up with it.
    always_comb begin
        state_out_d = 2'b00;
        colpos_d    = IDLE_IDX;
        game_over_d = 1'b0;
        case (state_d)
            S_TURN, S_CHECK: state_out_d = player_d ? 2'b10 : 2'b01;
            S_PLACE: begin
                state_out_d = player_d ? 2'b10 : 2'b01;
                colpos_d    = land_idx_c;
            end
            S_END: begin
                state_out_d = 2'b11;
                game_over_d = 1'b1;
            end
            default: state_out_d = 2'b00;
        endcase
    end

    assign bus.state_out       = state_out_q;
    assign bus.column_position = colpos_q;
    assign bus.cursor          = cursor_q;
    assign bus.current_player  = player_q;
    assign bus.board_occupied  = occ_q;
    assign bus.board_owner     = own_q;
    assign bus.winner          = winner_q;
    assign bus.game_over       = game_over_q;
endmodule

// File: tb/tb_connect4_turn_controller.sv
// Scoreboard bench for connect4_turn_controller: stimulus queues expected
// field values tagged with a cycle number, a negedge monitor compares them.
module tb_connect4_turn_controller;
    localparam int F_ST = 0, F_CP = 1, F_CUR = 2, F_PL = 3;
    localparam int F_OCC = 4, F_OWN = 5, F_WIN = 6, F_GO = 7;

    typedef struct {
        int          cyc;
        int          fld;
        logic [15:0] val;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    connect4_turn_controller_if bus ();
    connect4_turn_controller dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          tcur;
    logic        tpl;
    logic [1:0]  tst;
    logic [15:0] mocc, mown;
    int          hgt[4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] fieldv(input int f);
        case (f)
            F_ST:    return 16'(bus.state_out);
            F_CP:    return 16'(bus.column_position);
            F_CUR:   return 16'(bus.cursor);
            F_PL:    return 16'(bus.current_player);
            F_OCC:   return bus.board_occupied;
            F_OWN:   return bus.board_owner;
            F_WIN:   return 16'(bus.winner);
            default: return 16'(bus.game_over);
        endcase
    endfunction

    // Monitor: pop every expectation due this cycle; anything overdue is a failure.
    always @(negedge clk) begin
        int i;
        logic [15:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = fieldv(sb[i].fld);
                n_total++;
                if (act === sb[i].val) n_pass++;
                else $display("FAIL %s (cycle %0d): got %h expected %h", sb[i].nm, cyc, act, sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_total++;
                $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].nm, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic ex(input int dc, input int f, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + dc;
        e.fld = f;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic press(input logic s, input logic l, input logic r, input logic d);
        bus.start = s; bus.btn_left = l; bus.btn_right = r; bus.btn_drop = d;
        @(negedge clk);
        bus.start = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_drop = 1'b0;
    endtask

    task automatic reset_start();
        reset = 1'b1;
        ex(1, F_ST, 16'h0, "rst_state");   ex(1, F_CP, 16'h1F, "rst_colpos");
        ex(1, F_CUR, 16'h0, "rst_cursor"); ex(1, F_PL, 16'h0, "rst_player");
        ex(1, F_OCC, 16'h0, "rst_occ");    ex(1, F_OWN, 16'h0, "rst_own");
        ex(1, F_WIN, 16'h0, "rst_winner"); ex(1, F_GO, 16'h0, "rst_game_over");
        @(negedge clk);
        reset = 1'b0;
        ex(1, F_ST, 16'h1, "start_state"); ex(1, F_CUR, 16'h0, "start_cursor");
        ex(1, F_CP, 16'h1F, "start_colpos");
        press(1'b1, 1'b0, 1'b0, 1'b0);
        tcur = 0; tpl = 1'b0; tst = 2'b01; mocc = '0; mown = '0;
        for (int c = 0; c < 4; c++) hgt[c] = 0;
    endtask

    task automatic goto_col(input int col);
        while (tcur != col) begin
            tcur = (tcur + 1) % 4;
            ex(1, F_CUR, 16'(tcur), "cursor_right");
            press(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic drop(input logic [1:0] st_next, input logic [1:0] w_next);
        int idx;
        idx = tcur + 4 * hgt[tcur];
        hgt[tcur]++;
        mocc[idx] = 1'b1;
        mown[idx] = tpl;
        ex(1, F_CP, 16'(idx), "drop_index");   ex(1, F_ST, 16'(tst), "place_state");
        ex(2, F_CP, 16'h1F, "check_colpos");   ex(2, F_OCC, mocc, "occupied");
        ex(2, F_OWN, mown, "owner");           ex(3, F_ST, 16'(st_next), "next_state");
        ex(3, F_WIN, 16'(w_next), "winner");   ex(3, F_GO, 16'(st_next == 2'b11), "game_over");
        press(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        tst = st_next;
        tpl = (st_next == 2'b10);
    endtask

    task automatic drop_full();
        ex(1, F_ST, 16'(tst), "full_state1"); ex(1, F_CP, 16'h1F, "full_colpos1");
        ex(2, F_CP, 16'h1F, "full_colpos2"); ex(3, F_ST, 16'(tst), "full_state3");
        ex(3, F_OCC, mocc, "full_occ");
        press(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int draw_cols[16];
        draw_cols = '{0, 2, 2, 0, 0, 2, 2, 0, 1, 3, 3, 1, 1, 3, 3, 1};
        bus.start = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_drop = 1'b0;
        @(negedge clk);

        // First move: P1 drops in column 0
        reset_start();
        drop(2'b10, 2'b00);

        // Fill column 2, then a fifth drop is ignored
        reset_start();
        goto_col(2);
        drop(2'b10, 2'b00); drop(2'b01, 2'b00); drop(2'b10, 2'b00); drop(2'b01, 2'b00);
        drop_full();

        // Cursor wrap and simultaneous left/right
        reset_start();
        ex(1, F_CUR, 16'd3, "left_wrap");   press(1'b0, 1'b1, 1'b0, 1'b0);
        ex(1, F_CUR, 16'd0, "right_wrap");  press(1'b0, 1'b0, 1'b1, 1'b0);
        ex(1, F_CUR, 16'd0, "left_and_right"); press(1'b0, 1'b1, 1'b1, 1'b0);
        tcur = 0;

        // P1 completes row 0
        reset_start();
        drop(2'b10, 2'b00);
        drop(2'b01, 2'b00);
        goto_col(1); drop(2'b10, 2'b00);
        goto_col(0); drop(2'b01, 2'b00);
        goto_col(2); drop(2'b10, 2'b00);
        goto_col(0); drop(2'b01, 2'b00);
        goto_col(3); drop(2'b11, 2'b01);
        ex(1, F_ST, 16'h3, "end_ignores_drop"); ex(1, F_CP, 16'h1F, "end_colpos");
        ex(1, F_WIN, 16'h1, "end_winner_hold");
        press(1'b0, 1'b0, 1'b0, 1'b1);
        ex(1, F_ST, 16'h0, "end_to_init");   ex(1, F_OCC, 16'h0, "init_occ_clear");
        ex(1, F_OWN, 16'h0, "init_own_clear"); ex(1, F_WIN, 16'h0, "init_winner_clear");
        ex(1, F_CUR, 16'h0, "init_cursor_clear"); ex(1, F_GO, 16'h0, "init_game_over");
        press(1'b1, 1'b0, 1'b0, 1'b0);
        ex(1, F_ST, 16'h1, "restart_state");
        press(1'b1, 1'b0, 1'b0, 1'b0);

        // Draw: full board with no line owned by one player
        reset_start();
        for (int k = 0; k < 16; k++) begin
            goto_col(draw_cols[k]);
            if (k == 15) drop(2'b11, 2'b11);
            else drop((k % 2 == 0) ? 2'b10 : 2'b01, 2'b00);
        end

        // Reset while in S_PLACE
        reset_start();
        ex(1, F_CP, 16'h0, "place_before_reset");
        bus.btn_drop = 1'b1;
        @(negedge clk);
        bus.btn_drop = 1'b0;
        reset = 1'b1;
        ex(1, F_ST, 16'h0, "midplace_rst_state"); ex(1, F_CP, 16'h1F, "midplace_rst_colpos");
        ex(1, F_OCC, 16'h0, "midplace_rst_occ");  ex(1, F_OWN, 16'h0, "midplace_rst_own");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        foreach (sb[i]) begin
            n_total++;
            $display("FAIL %s: expectation for cycle %0d still pending", sb[i].nm, sb[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/connect4_turn_controller.md
Name: connect4_turn_controller

Overview:
Sequencing controller for the 4x4 Connect-4 board datapath (the column/cell selector that marks occupied cells and owners).
- Takes debounced single-cycle button pulses (left/right/drop/start) and moves a column cursor.
- Computes the landing cell for a drop (lowest empty row in the cursor column) and drives the datapath's state and cell index.
- Keeps a shadow board and detects 4-in-a-row wins and draws.

Parameters:
- N_COLS, 4, board columns (fixed 4; index = row*4 + col, row 0 = bottom)
- N_ROWS, 4, board rows
- IDLE_IDX, 5'b11111, cell-index value meaning "no placement"

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high; returns block to S_INIT
- start  in  1  one-cycle pulse: begin game / leave end-of-game
- btn_left  in  1  one-cycle pulse: cursor column - 1 (wraps)
- btn_right  in  1  one-cycle pulse: cursor column + 1 (wraps)
- btn_drop  in  1  one-cycle pulse: drop token in cursor column
- state_out  out  2  datapath state: 00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME
- column_position  out  5  cell index to mark; IDLE_IDX when no placement
- cursor  out  2  current column 0-3
- current_player  out  1  0 = P1, 1 = P2
- board_occupied  out  16  shadow board, 1 = occupied
- board_owner  out  16  shadow owner, 0 = P1, 1 = P2 (valid where occupied)
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- game_over  out  1  high while in S_END

Behaviour:
Reset values (applied on the clk edge where reset=1):
- fsm = S_INIT, state_out = 00, column_position = IDLE_IDX, cursor = 0, current_player = 0, boards = 0, winner = 00, game_over = 0.
- Reset overrides every other input in the same cycle, including mid-placement.

FSM states and transitions:
- S_INIT: state_out = 00; boards, winner and cursor held at 0. start → S_TURN with current_player = 0.
- S_TURN: state_out = 01 if current_player = 0, else 10. Input priority is drop > left/right.
  - btn_drop with column not full (top cell row 3 of cursor column unoccupied) → S_PLACE; the landing index is latched.
  - btn_drop on a full column is ignored; the FSM stays in S_TURN.
  - btn_left alone: cursor = (cursor - 1) mod 4. btn_right alone: cursor = (cursor + 1) mod 4.
  - btn_left and btn_right together: no cursor change.
- S_PLACE (exactly 1 cycle):
  - state_out unchanged; column_position = latched landing index.
  - On exit, board_occupied[idx] <= 1 and board_owner[idx] <= current_player.
  - Next state S_CHECK.
- S_CHECK (1 cycle): column_position = IDLE_IDX. The updated board is evaluated over 10 lines: 4 rows, 4 columns, 2 diagonals (0,5,10,15 and 3,6,9,12).
  - Line fully owned by current_player → S_END, winner = current_player + 1.
  - Otherwise, all 16 cells occupied → S_END, winner = 11.
  - Otherwise → S_TURN, current_player toggled; cursor keeps its value.
- S_END: state_out = 11, game_over = 1. Shadow board and winner hold for display. start → S_INIT, which clears the board, winner and cursor.

Buttons and timing:
- Buttons are ignored outside S_TURN; start is ignored in S_TURN, S_PLACE and S_CHECK.
- column_position equals IDLE_IDX in every state except S_PLACE.
- Drop latency: btn_drop in cycle N, then column_position valid in N+1, then board_occupied updated in N+2, then new player's state_out (or 11) in N+3.
- Landing index = min row r with cell r*4 + cursor empty; r*4 + cursor computed in 5 bits, upper bit 0.

Test Plan:
- Reset then start → state_out = 01, cursor = 0, column_position = 5'b11111. One btn_drop → column_position = 0 for one cycle, board_occupied = 16'h0001, then state_out = 10.
- Four alternating drops in column 2 (P1,P2,P1,P2) → indices 2, 6, 10, 14. A fifth drop in column 2 is ignored: no S_PLACE, state_out stays 01.
- Cursor at 0: btn_left → 3; btn_right → 0; btn_left and btn_right in the same cycle → 0.
- P1 drops in columns 0,1,2,3 with P2 always dropping in column 0 → P1 completes row 0 (cells 0-3). Required: winner = 01, game_over = 1, state_out = 11. Then start → state_out = 00 with boards = 0; start again → 01.
- Fill all 16 cells in an order that produces no 4-in-a-row → winner = 11 after the 16th placement.
- Assert reset during S_PLACE → next cycle state_out = 00, column_position = 5'b11111, boards = 0.
